// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding memory requests feeding a 2-entry {instr, pc} queue.
// Optional FETCH_PERF_CNT_EN adds a delivered-instruction counter on perf_fetch_count.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic [31:0] perf_fetch_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t      state_reg, state_next;
    logic [31:0] fetch_pc_reg, fetch_pc_next;
    logic [1:0]  count_reg, count_next;
    logic        rd_ptr_reg, rd_ptr_next;
    logic        wr_ptr_reg, wr_ptr_next;
    logic        push;
    logic        pop;
    logic        req_ok;

    // Requests stop while a branch redirects, the queue is full, or reset is held.
    assign req_ok    = (state_reg == IDLE) && (count_reg < 2'd2) && !branch_taken && !reset;
    assign imem_req  = req_ok;
    assign imem_addr = fetch_pc_reg;

    assign instr_valid = (count_reg != 2'd0);
    assign pop         = instr_valid && instr_ready && !branch_taken;

    always_comb begin
        state_next    = state_reg;
        fetch_pc_next = fetch_pc_reg;
        push          = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req_ok) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (branch_taken) begin
                    state_next = imem_valid ? IDLE : DISCARD;
                end else if (imem_valid) begin
                    push          = 1'b1;
                    fetch_pc_next = fetch_pc_reg + 32'd4;
                    state_next    = IDLE;
                end
            end
            DISCARD: begin
                if (imem_valid) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (branch_taken) begin
            fetch_pc_next = branch_target & ~32'd3;
        end
    end

    always_comb begin
        count_next  = count_reg;
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        if (branch_taken) begin
            count_next  = 2'd0;
            rd_ptr_next = 1'b0;
            wr_ptr_next = 1'b0;
        end else begin
            count_next  = count_reg + {1'b0, push} - {1'b0, pop};
            rd_ptr_next = rd_ptr_reg ^ pop;
            wr_ptr_next = wr_ptr_reg ^ push;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            fetch_pc_reg <= RESET_PC;
            count_reg    <= 2'd0;
            rd_ptr_reg   <= 1'b0;
            wr_ptr_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            count_reg    <= count_next;
            rd_ptr_reg   <= rd_ptr_next;
            wr_ptr_reg   <= wr_ptr_next;
        end
    end

    // Queue payload needs no reset: occupancy alone decides what is visible.
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        logic [31:0] instr_q;
        logic [31:0] pc_q;
        always_ff @(posedge clk) begin
            if (push && (wr_ptr_reg == 1'(gi))) begin
                instr_q <= imem_rdata;
                pc_q    <= imem_addr;
            end
        end
    end

    assign instr_out = rd_ptr_reg ? g_entry[1].instr_q : g_entry[0].instr_q;
    assign pc_out    = rd_ptr_reg ? g_entry[1].pc_q    : g_entry[0].pc_q;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_count_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_count_reg <= 32'd0;
        end else if (pop) begin
            perf_count_reg <= perf_count_reg + 32'd1;
        end
    end

    assign perf_fetch_count = perf_count_reg;
`else
    assign perf_fetch_count = 32'd0;
`endif

endmodule
